// File: rtl/wb_uart_rx_os.sv
// wb_uart_rx_os -- oversampling UART receiver with a Wishbone read port.
//
// Receives 5..8 data bits (LSB first), with optional even/odd parity and one
// stop bit. The line is sampled with an OVERSAMPLE x tick and a 3-tick
// majority vote ending at the bit centre. Received bytes and their error flags
// are stored in a circular FIFO of 2**FIFO_AW entries.
//
// Ports:
//   i_clk, i_reset      system clock, synchronous active-high reset
//   i_wb_cyc, i_wb_stb  Wishbone read request (single-cycle strobe)
//   i_wb_addr           0 = pop data, 1 = status
//   o_wb_data, o_wb_ack read data / acknowledge, one cycle after the strobe
//   o_wb_stall          tied low
//   uart_rx             asynchronous serial input
//   uart_empty          FIFO empty
//   o_frame_err         head entry carries a framing error
//   o_parity_err        head entry carries a parity error
//   o_overrun           sticky: a byte was dropped on a full FIFO
module wb_uart_rx_os #(
  parameter int DATA_BITS      = 8,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0,
  parameter int OVERSAMPLE     = 16,
  parameter int BAUD_DIV       = 163,
  parameter int BAUD_DIV_WIDTH = 8,
  parameter int FIFO_AW        = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wb_cyc,
  input  logic       i_wb_stb,
  input  logic       i_wb_addr,
  output logic [7:0] o_wb_data,
  output logic       o_wb_ack,
  output logic       o_wb_stall,
  input  logic       uart_rx,
  output logic       uart_empty,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_overrun
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam bit ODD   = (PARITY_ODD != 0);
  localparam logic [OS_W-1:0]           SAMPLE_PT = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BAUD_DIV_WIDTH-1:0] BAUD_LAST = BAUD_DIV_WIDTH'(BAUD_DIV - 1);
  localparam logic [2:0]                LAST_BIT  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_error(input logic [7:0] d, input logic p);
    return ((^d) ^ p) != ODD;
  endfunction

  state_t                    state;
  logic                      rx_meta, rx_s;
  logic [BAUD_DIV_WIDTH-1:0] baud_cnt;
  logic [OS_W-1:0]           os_cnt;
  logic [2:0]                bit_cnt;
  logic [1:0]                vote_hist;
  logic [7:0]                shreg;
  logic                      par_err_r;
  logic                      tick, sample_pt, vote, start_det;

  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr, rd_ptr;
  logic [9:0]         head;
  logic               fifo_empty, fifo_full;
  logic               bus_req, pop, push, push_ok, overrun_evt, stat_ack;
  logic [7:0]         status;

  // ---- input synchroniser ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // ---- bit timing and voting ----
  assign start_det = (state == S_IDLE) && !rx_s;
  assign tick      = (state != S_IDLE) && (baud_cnt == BAUD_LAST);
  assign sample_pt = tick && (os_cnt == SAMPLE_PT);
  // The current rx_s is the third (newest) tick of the vote window.
  assign vote      = maj3(vote_hist[1], vote_hist[0], rx_s);

  always_ff @(posedge i_clk) begin
    if (start_det) begin
      // The detect itself saw a low line, so seed the history with zeros.
      vote_hist <= 2'b00;
      shreg     <= '0;
    end else begin
      if (tick) vote_hist <= {vote_hist[0], rx_s};
      if (state == S_DATA && sample_pt) shreg[bit_cnt] <= vote;
    end
  end

  // ---- receive FSM ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      par_err_r <= 1'b0;
    end else begin
      if (state == S_IDLE || tick) baud_cnt <= '0;
      else                         baud_cnt <= baud_cnt + 1'b1;
      if (tick) os_cnt <= os_cnt + 1'b1;

      case (state)
        S_IDLE: if (!rx_s) begin
          state     <= S_START;
          os_cnt    <= '0;
          bit_cnt   <= '0;
          par_err_r <= 1'b0;
        end
        S_START: if (sample_pt) state <= vote ? S_IDLE : S_DATA;
        S_DATA: if (sample_pt) begin
          if (bit_cnt == LAST_BIT) state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          else                     bit_cnt <= bit_cnt + 1'b1;
        end
        S_PARITY: if (sample_pt) begin
          par_err_r <= parity_error(shreg, vote);
          state     <= S_STOP;
        end
        S_STOP: if (sample_pt) state <= rx_s ? S_IDLE : S_BREAK;
        S_BREAK: if (rx_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- FIFO ----
  assign push        = (state == S_STOP) && sample_pt;
  assign bus_req     = i_wb_cyc && i_wb_stb;
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign head        = mem[rd_ptr[FIFO_AW-1:0]];
  assign pop         = bus_req && !i_wb_addr && !fifo_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok     = push && (!fifo_full || pop);
  assign overrun_evt = push && fifo_full && !pop;

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= {par_err_r, !vote, shreg};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---- Wishbone read port ----
  assign uart_empty   = fifo_empty;
  assign o_frame_err  = !fifo_empty && head[8];
  assign o_parity_err = !fifo_empty && head[9];
  assign o_wb_stall   = 1'b0;
  assign status       = {4'b0, o_overrun, o_parity_err, o_frame_err, !fifo_empty};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
      stat_ack  <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_wb_ack <= bus_req;
      stat_ack <= bus_req && i_wb_addr;
      if (!bus_req)        o_wb_data <= '0;
      else if (i_wb_addr)  o_wb_data <= status;
      else if (fifo_empty) o_wb_data <= '0;
      else                 o_wb_data <= head[7:0];
      // A fresh overrun outranks the clear-on-read of the status ack.
      if (overrun_evt)                o_overrun <= 1'b1;
      else if (o_wb_ack && stat_ack)  o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_uart_rx_os.sv
// Testbench for wb_uart_rx_os: two instances at BAUD_DIV=2, OVERSAMPLE=4,
// one 8N1 with a 4-entry FIFO (a) and one 7E1 (b). Directed frames with
// hand-computed expected status/data, plus sequences for glitch, break,
// overflow and mid-frame reset.
module tb_wb_uart_rx_os;

  localparam int BIT_CYC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, cyc_a, stb_a, addr_a, rx_a;
  logic [7:0] data_a;
  logic       ack_a, stall_a, empty_a, ferr_a, perr_a, ovr_a;
  logic       rst_b, cyc_b, stb_b, addr_b, rx_b;
  logic [7:0] data_b;
  logic       ack_b, stall_b, empty_b, ferr_b, perr_b, ovr_b;

  int n_checks = 0;
  int n_fail   = 0;

  wb_uart_rx_os #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .OVERSAMPLE(4),
                  .BAUD_DIV(2), .BAUD_DIV_WIDTH(2), .FIFO_AW(2)) dut_a (
    .i_clk(clk), .i_reset(rst_a), .i_wb_cyc(cyc_a), .i_wb_stb(stb_a),
    .i_wb_addr(addr_a), .o_wb_data(data_a), .o_wb_ack(ack_a),
    .o_wb_stall(stall_a), .uart_rx(rx_a), .uart_empty(empty_a),
    .o_frame_err(ferr_a), .o_parity_err(perr_a), .o_overrun(ovr_a));

  wb_uart_rx_os #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .OVERSAMPLE(4),
                  .BAUD_DIV(2), .BAUD_DIV_WIDTH(2), .FIFO_AW(2)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_wb_cyc(cyc_b), .i_wb_stb(stb_b),
    .i_wb_addr(addr_b), .o_wb_data(data_b), .o_wb_ack(ack_b),
    .o_wb_stall(stall_b), .uart_rx(rx_b), .uart_empty(empty_b),
    .o_frame_err(ferr_b), .o_parity_err(perr_b), .o_overrun(ovr_b));

  typedef struct {
    bit         sel;
    logic [7:0] data;
    int         nbits;
    bit         has_par;
    bit         par;
    logic [7:0] exp_status;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic wb_read(input bit sel, input logic addr, output logic [7:0] d);
    @(posedge clk); #1;
    if (sel) begin cyc_b = 1'b1; stb_b = 1'b1; addr_b = addr; end
    else     begin cyc_a = 1'b1; stb_a = 1'b1; addr_a = addr; end
    @(posedge clk); #1;
    cyc_a = 1'b0; stb_a = 1'b0; addr_a = 1'b0;
    cyc_b = 1'b0; stb_b = 1'b0; addr_b = 1'b0;
    check(addr ? "status_ack" : "data_ack", sel ? ack_b : ack_a, 1);
    d = sel ? data_b : data_a;
  endtask

  // Drives one frame; with chk set, verifies uart_empty drops exactly after
  // the stop-bit sample edge (7th clock edge into the stop bit).
  task automatic send_frame(input bit sel, input logic [7:0] d, input int nbits,
                            input bit has_par, input bit par, input logic stop_val,
                            input int stop_bits, input bit chk);
    @(posedge clk); #1;
    set_rx(sel, 1'b0);
    repeat (BIT_CYC) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      #1 set_rx(sel, d[i]);
      repeat (BIT_CYC) @(posedge clk);
    end
    if (has_par) begin
      #1 set_rx(sel, par);
      repeat (BIT_CYC) @(posedge clk);
    end
    #1 set_rx(sel, stop_val);
    if (chk) begin
      repeat (6) @(posedge clk);
      #1 check("empty_before_stop_sample", empty_a, 1);
      @(posedge clk);
      #1 check("empty_after_stop_sample", empty_a, 0);
      repeat (BIT_CYC * stop_bits - 7) @(posedge clk);
    end else begin
      repeat (BIT_CYC * stop_bits) @(posedge clk);
    end
    #1 set_rx(sel, 1'b1);
  endtask

  task automatic check_reset_a();
    check("rst_wb_data", data_a, 8'h00);
    check("rst_wb_ack", ack_a, 0);
    check("rst_wb_stall", stall_a, 0);
    check("rst_empty", empty_a, 1);
    check("rst_frame_err", ferr_a, 0);
    check("rst_parity_err", perr_a, 0);
    check("rst_overrun", ovr_a, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    vecs[0] = '{0, 8'hA5, 8, 0, 0, 8'h01, 8'hA5};
    vecs[1] = '{0, 8'h00, 8, 0, 0, 8'h01, 8'h00};
    vecs[2] = '{0, 8'hFF, 8, 0, 0, 8'h01, 8'hFF};
    vecs[3] = '{1, 8'h41, 7, 1, 0, 8'h01, 8'h41};
    vecs[4] = '{1, 8'h41, 7, 1, 1, 8'h05, 8'h41};
    vecs[5] = '{1, 8'h7F, 7, 1, 1, 8'h01, 8'h7F};

    rst_a = 1'b1; rst_b = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    cyc_a = 1'b0; stb_a = 1'b0; addr_a = 1'b0;
    cyc_b = 1'b0; stb_b = 1'b0; addr_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_a();
    check("rst_b_empty", empty_b, 1);
    check("rst_b_ack", ack_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (5) @(posedge clk);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].nbits, vecs[i].has_par,
                 vecs[i].par, 1'b1, 1, i == 0);
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("v%0d_frame_err", i), vecs[i].sel ? ferr_b : ferr_a, vecs[i].exp_status[1]);
      check($sformatf("v%0d_parity_err", i), vecs[i].sel ? perr_b : perr_a, vecs[i].exp_status[2]);
      wb_read(vecs[i].sel, 1'b1, rd);
      check($sformatf("v%0d_status", i), rd, vecs[i].exp_status);
      wb_read(vecs[i].sel, 1'b0, rd);
      check($sformatf("v%0d_data", i), rd, vecs[i].exp_data);
      wb_read(vecs[i].sel, 1'b1, rd);
      check($sformatf("v%0d_status_after", i), rd, 8'h00);
    end

    // Glitch of one tick period in IDLE: false start, no push
    @(posedge clk); #1 rx_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("glitch_empty", empty_a, 1);
    wb_read(0, 1'b1, rd);
    check("glitch_status", rd, 8'h00);

    // Break: stop bit held low for 3 bit times
    send_frame(0, 8'h3C, 8, 0, 0, 1'b0, 3, 0);
    repeat (20) @(posedge clk);
    #1 check("break_frame_err", ferr_a, 1);
    wb_read(0, 1'b1, rd);
    check("break_status", rd, 8'h03);
    wb_read(0, 1'b0, rd);
    check("break_data", rd, 8'h3C);
    wb_read(0, 1'b1, rd);
    check("break_status_after", rd, 8'h00);

    // Overflow of the 4-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(0, 8'(i), 8, 0, 0, 1'b1, 1, 0);
      repeat (2) @(posedge clk);
    end
    #1 check("ovf_overrun_flag", ovr_a, 1);
    wb_read(0, 1'b1, rd);
    check("ovf_status", rd, 8'h09);
    for (int i = 1; i <= 4; i++) begin
      wb_read(0, 1'b0, rd);
      check($sformatf("ovf_data%0d", i), rd, 8'(i));
    end
    wb_read(0, 1'b0, rd);
    check("ovf_data_empty", rd, 8'h00);
    wb_read(0, 1'b1, rd);
    check("ovf_status_after", rd, 8'h00);

    // Reset in the middle of DATA with a byte already queued
    send_frame(0, 8'h77, 8, 0, 0, 1'b1, 1, 0);
    repeat (4) @(posedge clk);
    #1 check("pre_reset_nonempty", empty_a, 0);
    @(posedge clk); #1 rx_a = 1'b0;
    repeat (3 * BIT_CYC) @(posedge clk);
    #1 rx_a = 1'b1; rst_a = 1'b1;
    @(posedge clk);
    #1 rst_a = 1'b0;
    check_reset_a();
    repeat (20) @(posedge clk);
    #1 check("post_reset_empty", empty_a, 1);
    send_frame(0, 8'h5A, 8, 0, 0, 1'b1, 1, 0);
    repeat (4) @(posedge clk);
    wb_read(0, 1'b1, rd);
    check("post_reset_status", rd, 8'h01);
    wb_read(0, 1'b0, rd);
    check("post_reset_data", rd, 8'h5A);
    wb_read(0, 1'b1, rd);
    check("post_reset_status_after", rd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
